// File: rtl/edge_pkg.sv
// Shared constants and helpers for the RGB-to-luma 3x3 window front end.
// Imported by gray_window_3x3 and its line buffers.
package edge_pkg;
    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;
    localparam int PIX_W_DEF      = 8;

    localparam int COL_W = 10;
    localparam int ROW_W = 9;

    // Y = (77R + 150G + 29B) >> 8; the coefficients sum to 256, so no saturation
    localparam int LUMA_CR    = 77;
    localparam int LUMA_CG    = 150;
    localparam int LUMA_CB    = 29;
    localparam int LUMA_SHIFT = 8;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } pos_t;

    // Flat tap index of window position (r,c); r=0 is the oldest row, c=0 the leftmost
    function automatic logic [3:0] tap_idx(input int r, input int c);
        return 4'(3 * r + c);
    endfunction
endpackage

// File: rtl/line_buffer.sv
// One line of luma history. Single address port: the address is registered,
// read data is combinational from it, and a write lands at that same address.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             addr_en_i,
    input  logic [AW-1:0]    addr_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            addr_q <= '0;
        else if (addr_en_i) addr_q <= addr_i;
    end

    // Contents are deliberately not reset; stale rows are never emitted
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_q];
endmodule

// File: rtl/gray_window_3x3.sv
// RGB raster stream -> luma -> 3x3 luma window with centre coordinates.
// Two-clock latency: stage 1 registers luma/position, stage 2 shifts the window.
module gray_window_3x3
    import edge_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   in_R,
    input  logic [PIX_W-1:0]   in_G,
    input  logic [PIX_W-1:0]   in_B,
    input  logic               in_valid,
    input  logic               edge_en,
    output logic [9*PIX_W-1:0] win,
    output logic               win_valid,
    output logic [ROW_W-1:0]   center_row,
    output logic [COL_W-1:0]   center_col,
    output logic               frame_done
);
    localparam int               SUM_W    = PIX_W + LUMA_SHIFT;
    localparam int               LB_AW    = $clog2(IMG_WIDTH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic                  accept, adv, qual;
    logic [SUM_W-1:0]      luma_sum;
    logic [PIX_W-1:0]      luma;
    pos_t                  pos_q, pos_d, s1_pos_q;
    logic [PIX_W-1:0]      s1_y_q;
    logic                  v1_q;
    logic [PIX_W-1:0]      lb0_rd, lb1_rd;
    logic [8:0][PIX_W-1:0] win_q, win_d;
    logic                  win_valid_q, win_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic [ROW_W-1:0]      crow_q;
    logic [COL_W-1:0]      ccol_q;

    assign accept = in_valid & edge_en;
    assign adv    = v1_q & edge_en;

    assign luma_sum = SUM_W'(LUMA_CR) * SUM_W'(in_R)
                    + SUM_W'(LUMA_CG) * SUM_W'(in_G)
                    + SUM_W'(LUMA_CB) * SUM_W'(in_B);
    assign luma     = PIX_W'(luma_sum >> LUMA_SHIFT);

    always_comb begin
        pos_d = pos_q;
        if (!edge_en) begin
            pos_d = '0;
        end else if (in_valid) begin
            if (pos_q.col == COL_LAST) begin
                pos_d.col = '0;
                pos_d.row = (pos_q.row == ROW_LAST) ? '0 : pos_q.row + 1'b1;
            end else begin
                pos_d.col = pos_q.col + 1'b1;
            end
        end
    end

    // lb0 holds the previous line, lb1 the one before; both addressed by the stage-1 column
    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
        .clk(clk), .rst(rst),
        .addr_en_i(accept), .addr_i(pos_q.col[LB_AW-1:0]),
        .we_i(adv), .wdata_i(s1_y_q), .rdata_o(lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
        .clk(clk), .rst(rst),
        .addr_en_i(accept), .addr_i(pos_q.col[LB_AW-1:0]),
        .we_i(adv), .wdata_i(lb0_rd), .rdata_o(lb1_rd)
    );

    always_comb begin
        win_d = win_q;
        if (adv) begin
            for (int r = 0; r < 3; r++) begin
                win_d[tap_idx(r, 0)] = win_q[tap_idx(r, 1)];
                win_d[tap_idx(r, 1)] = win_q[tap_idx(r, 2)];
            end
            win_d[tap_idx(0, 2)] = lb1_rd;
            win_d[tap_idx(1, 2)] = lb0_rd;
            win_d[tap_idx(2, 2)] = s1_y_q;
        end
    end

    assign qual         = (s1_pos_q.row >= ROW_W'(2)) && (s1_pos_q.col >= COL_W'(2));
    assign win_valid_d  = adv & qual;
    assign frame_done_d = adv & (s1_pos_q.row == ROW_LAST) & (s1_pos_q.col == COL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q        <= '0;
            s1_pos_q     <= '0;
            s1_y_q       <= '0;
            v1_q         <= 1'b0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            crow_q       <= '0;
            ccol_q       <= '0;
        end else begin
            pos_q        <= pos_d;
            v1_q         <= accept;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            if (accept) begin
                s1_y_q   <= luma;
                s1_pos_q <= pos_q;
            end
            if (win_valid_d) begin
                crow_q <= s1_pos_q.row - 1'b1;
                ccol_q <= s1_pos_q.col - 1'b1;
            end
        end
    end

    assign win        = win_q;
    assign win_valid  = win_valid_q;
    assign center_row = crow_q;
    assign center_col = ccol_q;
    assign frame_done = frame_done_q;
endmodule
